// File: rtl/branch_predictor_dual.sv
// Dual-slot 2-bit bimodal branch predictor with D->E prediction tracking and branch/mispredict counters.
// Optional BP_GSHARE_EN: XOR the PHT index with a global history register shifted on each update.
module branch_predictor_dual #(
   parameter int IDX_BITS = 6,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pcd_a,
   input  logic [31:0]      pcd_b,
   input  logic             branchd_a,
   input  logic             branchd_b,
   input  logic             stalle,
   input  logic             flushe,
   input  logic             branchIsCorrectE_a,
   input  logic             branchIsCorrectE_b,
   output logic             branchPredictedTakenD_a,
   output logic             branchPredictedTakenD_b,
   output logic             mispredictE_a,
   output logic             mispredictE_b,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int PHT_N = 1 << IDX_BITS;

   logic [1:0]          r_pht [PHT_N];
   logic                r_valid_a, r_valid_b;
   logic [IDX_BITS-1:0] r_idx_a, r_idx_b;
   logic                r_pred_a, r_pred_b;
   logic [CNT_W-1:0]    r_branch_cnt, r_mispredict_cnt;

   logic [IDX_BITS-1:0] w_idx_a, w_idx_b;
   logic [1:0]          w_rd_a, w_rd_b;
   logic                w_pred_a, w_pred_b;
   logic                w_upd_a, w_upd_b;
   logic                w_taken_a, w_taken_b;
   logic [1:0]          w_new_a, w_base_b, w_new_b;
   logic [1:0]          w_br_inc, w_mp_inc;
   logic [CNT_W:0]      w_br_sum, w_mp_sum;
   logic [CNT_W-1:0]    w_br_next, w_mp_next;
   logic                w_unused_pc;

   function automatic logic [1:0] f_step(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
   endfunction

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] r_ghr;
   assign w_idx_a = pcd_a[IDX_BITS+1:2] ^ r_ghr;
   assign w_idx_b = pcd_b[IDX_BITS+1:2] ^ r_ghr;

   // Older slot's outcome enters history first when both slots retire together.
   always_ff @(posedge clk) begin
      if (reset)
         r_ghr <= '0;
      else if (w_upd_a && w_upd_b)
         r_ghr <= {r_ghr[IDX_BITS-3:0], w_taken_a, w_taken_b};
      else if (w_upd_a)
         r_ghr <= {r_ghr[IDX_BITS-2:0], w_taken_a};
      else if (w_upd_b)
         r_ghr <= {r_ghr[IDX_BITS-2:0], w_taken_b};
   end
`else
   assign w_idx_a = pcd_a[IDX_BITS+1:2];
   assign w_idx_b = pcd_b[IDX_BITS+1:2];
`endif

   assign w_unused_pc = ^{pcd_a[31:IDX_BITS+2], pcd_a[1:0], pcd_b[31:IDX_BITS+2], pcd_b[1:0]};

   assign w_rd_a   = r_pht[w_idx_a];
   assign w_rd_b   = r_pht[w_idx_b];
   assign w_pred_a = branchd_a & w_rd_a[1];
   assign w_pred_b = branchd_b & w_rd_b[1];

   assign branchPredictedTakenD_a = w_pred_a;
   assign branchPredictedTakenD_b = w_pred_b;

   assign w_upd_a   = r_valid_a & ~stalle;
   assign w_upd_b   = r_valid_b & ~stalle;
   assign w_taken_a = r_pred_a ^ ~branchIsCorrectE_a;
   assign w_taken_b = r_pred_b ^ ~branchIsCorrectE_b;

   // Slot B sees slot A's result when both hit the same entry in one cycle.
   assign w_new_a  = f_step(r_pht[r_idx_a], w_taken_a);
   assign w_base_b = (w_upd_a && (r_idx_a == r_idx_b)) ? w_new_a : r_pht[r_idx_b];
   assign w_new_b  = f_step(w_base_b, w_taken_b);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
      end else begin
         if (w_upd_a) r_pht[r_idx_a] <= w_new_a;
         if (w_upd_b) r_pht[r_idx_b] <= w_new_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid_a <= 1'b0;
         r_valid_b <= 1'b0;
         r_idx_a   <= '0;
         r_idx_b   <= '0;
         r_pred_a  <= 1'b0;
         r_pred_b  <= 1'b0;
      end else if (flushe) begin
         r_valid_a <= 1'b0;
         r_valid_b <= 1'b0;
      end else if (!stalle) begin
         r_valid_a <= branchd_a;
         r_valid_b <= branchd_b;
         r_idx_a   <= w_idx_a;
         r_idx_b   <= w_idx_b;
         r_pred_a  <= w_pred_a;
         r_pred_b  <= w_pred_b;
      end
   end

   assign mispredictE_a = r_valid_a & ~branchIsCorrectE_a;
   assign mispredictE_b = r_valid_b & ~branchIsCorrectE_b;

   assign w_br_inc  = {1'b0, w_upd_a} + {1'b0, w_upd_b};
   assign w_mp_inc  = {1'b0, w_upd_a & ~branchIsCorrectE_a} + {1'b0, w_upd_b & ~branchIsCorrectE_b};
   assign w_br_sum  = {1'b0, r_branch_cnt} + {{(CNT_W-1){1'b0}}, w_br_inc};
   assign w_mp_sum  = {1'b0, r_mispredict_cnt} + {{(CNT_W-1){1'b0}}, w_mp_inc};
   assign w_br_next = w_br_sum[CNT_W] ? {CNT_W{1'b1}} : w_br_sum[CNT_W-1:0];
   assign w_mp_next = w_mp_sum[CNT_W] ? {CNT_W{1'b1}} : w_mp_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         r_branch_cnt     <= w_br_next;
         r_mispredict_cnt <= w_mp_next;
      end
   end

   assign branch_cnt     = r_branch_cnt;
   assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_dual.sv
// Self-checking bench for branch_predictor_dual: directed scenarios plus randomized traffic
// compared against an integer-array reference model of the predictor.
module tb_branch_predictor_dual;

   localparam int IDXB = 6;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pcd_a, pcd_b;
   logic          branchd_a, branchd_b, stalle, flushe;
   logic          branchIsCorrectE_a, branchIsCorrectE_b;
   logic          branchPredictedTakenD_a, branchPredictedTakenD_b;
   logic          mispredictE_a, mispredictE_b;
   logic [CW-1:0] branch_cnt, mispredict_cnt;

   branch_predictor_dual #(.IDX_BITS(IDXB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .pcd_a(pcd_a), .pcd_b(pcd_b),
      .branchd_a(branchd_a), .branchd_b(branchd_b),
      .stalle(stalle), .flushe(flushe),
      .branchIsCorrectE_a(branchIsCorrectE_a), .branchIsCorrectE_b(branchIsCorrectE_b),
      .branchPredictedTakenD_a(branchPredictedTakenD_a), .branchPredictedTakenD_b(branchPredictedTakenD_b),
      .mispredictE_a(mispredictE_a), .mispredictE_b(mispredictE_b),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: counter value 0..3 per entry, plus the branch sitting in E for each slot.
   int pht_m [64];
   int bcnt_m, mcnt_m;
   bit ev_a, ev_b, ep_a, ep_b, tk_a, tk_b;
   int ei_a, ei_b;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd63);
   endfunction

   function automatic bit mpred(input logic [31:0] pc, input logic br);
      return br && (pht_m[midx(pc)] >= 2);
   endfunction

   task automatic set_in(input logic [31:0] pa, input logic [31:0] pb, input bit ba, input bit bb,
                         input bit st, input bit fl, input bit ta, input bit tb);
      pcd_a = pa; pcd_b = pb; branchd_a = ba; branchd_b = bb;
      stalle = st; flushe = fl; tk_a = ta; tk_b = tb;
      branchIsCorrectE_a = ev_a ? (ep_a == ta) : 1'b1;
      branchIsCorrectE_b = ev_b ? (ep_b == tb) : 1'b1;
   endtask

   task automatic tick();
      bit pa, pb, ua, ub;
      int ia, ib;
      pa = mpred(pcd_a, branchd_a);
      pb = mpred(pcd_b, branchd_b);
      ia = midx(pcd_a);
      ib = midx(pcd_b);
      ua = ev_a && !stalle;
      ub = ev_b && !stalle;
      @(posedge clk);
      if (reset) begin
         foreach (pht_m[i]) pht_m[i] = 1;
         bcnt_m = 0; mcnt_m = 0; ev_a = 0; ev_b = 0;
      end else begin
         if (ua) begin
            pht_m[ei_a] = tk_a ? ((pht_m[ei_a] == 3) ? 3 : pht_m[ei_a] + 1)
                               : ((pht_m[ei_a] == 0) ? 0 : pht_m[ei_a] - 1);
            if (bcnt_m < CMAX) bcnt_m++;
            if (ep_a != tk_a && mcnt_m < CMAX) mcnt_m++;
         end
         if (ub) begin
            pht_m[ei_b] = tk_b ? ((pht_m[ei_b] == 3) ? 3 : pht_m[ei_b] + 1)
                               : ((pht_m[ei_b] == 0) ? 0 : pht_m[ei_b] - 1);
            if (bcnt_m < CMAX) bcnt_m++;
            if (ep_b != tk_b && mcnt_m < CMAX) mcnt_m++;
         end
         if (flushe) begin
            ev_a = 0; ev_b = 0;
         end else if (!stalle) begin
            ev_a = branchd_a; ei_a = ia; ep_a = pa;
            ev_b = branchd_b; ei_b = ib; ep_b = pb;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(32'h40, 32'h0, 1, 0, 0, 0, 0, 0);
      tick(); tick();
      reset = 1'b0;
      set_in(32'h40, 32'h80, 1, 1, 0, 0, 0, 0);
      #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b0) $display("FAIL reset_pred_a: got %b want 0", branchPredictedTakenD_a); else n_pass++;
      n_chk++; if (branchPredictedTakenD_b !== 1'b0) $display("FAIL reset_pred_b: got %b want 0", branchPredictedTakenD_b); else n_pass++;
      n_chk++; if (branch_cnt !== 8'd0) $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd0) $display("FAIL reset_mispredict_cnt: got %0d want 0", mispredict_cnt); else n_pass++;
      n_chk++; if ({mispredictE_a, mispredictE_b} !== 2'b00) $display("FAIL reset_mispredictE: got %b want 00", {mispredictE_a, mispredictE_b}); else n_pass++;
      tick();
   endtask

   task automatic test_train();
      do_reset();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b0) $display("FAIL train_pred0: got %b want 0", branchPredictedTakenD_a); else n_pass++;
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 1, 0); #1;
      n_chk++; if (mispredictE_a !== 1'b1) $display("FAIL train_mispredictE: got %b want 1", mispredictE_a); else n_pass++;
      n_chk++; if (branchPredictedTakenD_a !== 1'b0) $display("FAIL train_no_bypass: got %b want 0", branchPredictedTakenD_a); else n_pass++;
      tick();
      set_in(32'h40, 0, 0, 0, 0, 0, 1, 0); #1;
      n_chk++; if (branch_cnt !== 8'd1) $display("FAIL train_bcnt1: got %0d want 1", branch_cnt); else n_pass++;
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b1) $display("FAIL train_pred_taken: got %b want 1", branchPredictedTakenD_a); else n_pass++;
      n_chk++; if (branch_cnt !== 8'd2) $display("FAIL train_bcnt2: got %0d want 2", branch_cnt); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd2) $display("FAIL train_mcnt2: got %0d want 2", mispredict_cnt); else n_pass++;
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b1) $display("FAIL train_pred_strong: got %b want 1", branchPredictedTakenD_a); else n_pass++;
      tick();
      set_in(32'h40, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b0) $display("FAIL train_pred_back_nt: got %b want 0", branchPredictedTakenD_a); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd4) $display("FAIL train_mcnt4: got %0d want 4", mispredict_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_same_index();
      do_reset();
      set_in(32'h14, 32'h114, 1, 1, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 1); #1;
      n_chk++; if ({mispredictE_a, mispredictE_b} !== 2'b11) $display("FAIL same_mispredictE: got %b want 11", {mispredictE_a, mispredictE_b}); else n_pass++;
      tick();
      set_in(32'h14, 32'h114, 1, 1, 0, 0, 0, 1); #1;
      n_chk++; if ({branchPredictedTakenD_a, branchPredictedTakenD_b} !== 2'b11) $display("FAIL same_pred_taken: got %b want 11", {branchPredictedTakenD_a, branchPredictedTakenD_b}); else n_pass++;
      n_chk++; if (branch_cnt !== 8'd2) $display("FAIL same_bcnt2: got %0d want 2", branch_cnt); else n_pass++;
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      // 11 -> A not-taken -> 10 -> B taken -> 11; one more not-taken must still predict taken
      set_in(32'h14, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (mispredict_cnt !== 8'd3) $display("FAIL same_mcnt3: got %0d want 3", mispredict_cnt); else n_pass++;
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(32'h114, 0, 1, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b1) $display("FAIL same_entry11: got %b want 1", branchPredictedTakenD_a); else n_pass++;
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      set_in(32'h40, 32'h80, 1, 1, 0, 0, 0, 0);
      tick();
      set_in(32'h40, 32'h80, 1, 1, 1, 1, 1, 1); #1;
      n_chk++; if (mispredictE_a !== 1'b1) $display("FAIL flush_pre_mispredictE: got %b want 1", mispredictE_a); else n_pass++;
      tick();
      set_in(0, 0, 0, 0, 0, 0, 1, 1);
      branchIsCorrectE_a = 1'b0; branchIsCorrectE_b = 1'b0; #1;
      n_chk++; if ({mispredictE_a, mispredictE_b} !== 2'b00) $display("FAIL flush_validE: got %b want 00", {mispredictE_a, mispredictE_b}); else n_pass++;
      tick();
      set_in(32'h40, 32'h80, 1, 1, 0, 0, 0, 0); #1;
      n_chk++; if (branch_cnt !== 8'd0) $display("FAIL flush_bcnt: got %0d want 0", branch_cnt); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd0) $display("FAIL flush_mcnt: got %0d want 0", mispredict_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(32'h80, 32'h84, 1, 1, 1, 0, 1, 0); #1;
         n_chk++; if (mispredictE_a !== 1'b1) $display("FAIL stall_mispredictE[%0d]: got %b want 1", i, mispredictE_a); else n_pass++;
         n_chk++; if (branch_cnt !== 8'd0) $display("FAIL stall_bcnt[%0d]: got %0d want 0", i, branch_cnt); else n_pass++;
         tick();
      end
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
      n_chk++; if (branch_cnt !== 8'd1) $display("FAIL stall_release_bcnt: got %0d want 1", branch_cnt); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd1) $display("FAIL stall_release_mcnt: got %0d want 1", mispredict_cnt); else n_pass++;
      n_chk++; if ({mispredictE_a, mispredictE_b} !== 2'b00) $display("FAIL stall_release_validE: got %b want 00", {mispredictE_a, mispredictE_b}); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_in(32'h40, 0, 1, 0, 0, 0, 0, 0);
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 1, 0);
      tick();
      set_in(32'h40, 0, 1, 0, 0, 0, 1, 0); #1;
      n_chk++; if (branch_cnt !== 8'd1) $display("FAIL mid_pre_bcnt: got %0d want 1", branch_cnt); else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_in(32'h40, 0, 1, 0, 0, 0, 1, 0);
      branchIsCorrectE_a = 1'b0; #1;
      n_chk++; if (branchPredictedTakenD_a !== 1'b0) $display("FAIL mid_pred: got %b want 0", branchPredictedTakenD_a); else n_pass++;
      n_chk++; if ({branch_cnt, mispredict_cnt} !== 16'd0) $display("FAIL mid_counts: got %0d/%0d want 0/0", branch_cnt, mispredict_cnt); else n_pass++;
      n_chk++; if (mispredictE_a !== 1'b0) $display("FAIL mid_validE: got %b want 0", mispredictE_a); else n_pass++;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] pa, pb;
      do_reset();
      for (int c = 0; c < 240; c++) begin
         pa = ($urandom_range(0, 7) << 2) + ($urandom_range(0, 3) << 8);
         pb = ($urandom_range(0, 7) << 2) + ($urandom_range(0, 3) << 8);
         set_in(pa, pb, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 2,
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4);
         #1;
         n_chk++; if (branchPredictedTakenD_a !== mpred(pa, branchd_a)) $display("FAIL rand_pred_a c%0d: got %b want %b", c, branchPredictedTakenD_a, mpred(pa, branchd_a)); else n_pass++;
         n_chk++; if (branchPredictedTakenD_b !== mpred(pb, branchd_b)) $display("FAIL rand_pred_b c%0d: got %b want %b", c, branchPredictedTakenD_b, mpred(pb, branchd_b)); else n_pass++;
         n_chk++; if (mispredictE_a !== (ev_a && ep_a != tk_a)) $display("FAIL rand_misE_a c%0d: got %b want %b", c, mispredictE_a, (ev_a && ep_a != tk_a)); else n_pass++;
         n_chk++; if (mispredictE_b !== (ev_b && ep_b != tk_b)) $display("FAIL rand_misE_b c%0d: got %b want %b", c, mispredictE_b, (ev_b && ep_b != tk_b)); else n_pass++;
         n_chk++; if (int'(branch_cnt) !== bcnt_m) $display("FAIL rand_bcnt c%0d: got %0d want %0d", c, branch_cnt, bcnt_m); else n_pass++;
         n_chk++; if (int'(mispredict_cnt) !== mcnt_m) $display("FAIL rand_mcnt c%0d: got %0d want %0d", c, mispredict_cnt, mcnt_m); else n_pass++;
         tick();
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int c = 0; c < 135; c++) begin
         set_in(32'h20, 32'h24, 1, 1, 0, 0, ~ep_a, ~ep_b);
         #1;
         n_chk++; if (int'(branch_cnt) !== bcnt_m) $display("FAIL sat_bcnt c%0d: got %0d want %0d", c, branch_cnt, bcnt_m); else n_pass++;
         n_chk++; if (int'(mispredict_cnt) !== mcnt_m) $display("FAIL sat_mcnt c%0d: got %0d want %0d", c, mispredict_cnt, mcnt_m); else n_pass++;
         tick();
      end
      n_chk++; if (branch_cnt !== 8'd255) $display("FAIL sat_bcnt_max: got %0d want 255", branch_cnt); else n_pass++;
      n_chk++; if (mispredict_cnt !== 8'd255) $display("FAIL sat_mcnt_max: got %0d want 255", mispredict_cnt); else n_pass++;
   endtask

   initial begin
      ev_a = 0; ev_b = 0; ep_a = 0; ep_b = 0; ei_a = 0; ei_b = 0;
      bcnt_m = 0; mcnt_m = 0;
      foreach (pht_m[i]) pht_m[i] = 1;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_train();
      test_same_index();
      test_flush();
      test_stall();
      test_reset_mid();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
